// File: rtl/fetch_issue_unit_if.sv
// Instruction-memory fetch bus for fetch_issue_unit.
//   MEM_REQ   fetch request, held until MEM_ACK
//   MEM_ADDR  fetch address (PC_W bits)
//   MEM_ACK   memory response; MEM_DATA is valid in the same cycle
//   MEM_DATA  instruction word (INSTR_W bits)
// The master modport is the fetch unit. The slave modport is the instruction memory.
interface fetch_issue_unit_if #(
    parameter int PC_W    = 5,
    parameter int INSTR_W = 9
);
    logic               MEM_REQ;
    logic [PC_W-1:0]    MEM_ADDR;
    logic               MEM_ACK;
    logic [INSTR_W-1:0] MEM_DATA;

    modport master (output MEM_REQ, MEM_ADDR, input  MEM_ACK, MEM_DATA);
    modport slave  (input  MEM_REQ, MEM_ADDR, output MEM_ACK, MEM_DATA);
endinterface

// File: rtl/fetch_issue_unit.sv
// Instruction fetch and issue sequencer for the 5-bit CPU.
// It owns the program counter and fetches instruction words over a req/ack bus.
// It presents the registered opcode and operand to the control unit, takes the
// control unit's jump decision to pick the next PC, and stops on the HALT opcode.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   RUN          start/continue request (sampled in IDLE and at the end of ISSUE)
//   mem          fetch bus (master side): MEM_REQ/MEM_ADDR out, MEM_ACK/MEM_DATA in
//   Opcode       registered opcode, held between issues
//   OPERAND      registered operand/immediate/jump target, held between issues
//   INSTR_VALID  one-cycle strobe marking a newly issued instruction
//   JMP_SEL      jump decision from the control unit, used in ISSUE
//   PC           current program counter
//   HALTED       high once the HALT opcode has been issued
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | stopped or paused, PC retained; waits for RUN
// FETCH  | MEM_REQ high at MEM_ADDR=PC until MEM_ACK captures the word
// ISSUE  | INSTR_VALID strobe; next PC chosen, then FETCH or IDLE
// HALT   | HALT opcode seen; only reset leaves this state
module fetch_issue_unit #(
    parameter int          PC_W    = 5,
    parameter int          INSTR_W = 9,
    parameter logic [3:0]  HALT_OP = 4'b1111
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RUN,
    fetch_issue_unit_if.master   mem,
    output logic [3:0]           Opcode,
    output logic [4:0]           OPERAND,
    output logic                 INSTR_VALID,
    input  logic                 JMP_SEL,
    output logic [PC_W-1:0]      PC,
    output logic                 HALTED
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          state;
    logic [PC_W-1:0] next_pc;

    // The address is the PC itself, so it cannot move while a request is open.
    assign mem.MEM_ADDR = PC;

    // The PC_W-bit add wraps naturally (31 + 1 -> 0).
    assign next_pc = JMP_SEL ? PC_W'(OPERAND) : PC + PC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            PC          <= '0;
            Opcode      <= '0;
            OPERAND     <= '0;
            mem.MEM_REQ <= 1'b0;
            INSTR_VALID <= 1'b0;
            HALTED      <= 1'b0;
        end else begin
            INSTR_VALID <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (RUN) begin
                        state       <= S_FETCH;
                        mem.MEM_REQ <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (mem.MEM_ACK) begin
                        Opcode      <= mem.MEM_DATA[INSTR_W-1 -: 4];
                        OPERAND     <= mem.MEM_DATA[4:0];
                        mem.MEM_REQ <= 1'b0;
                        INSTR_VALID <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (Opcode == HALT_OP) begin
                        state  <= S_HALT;
                        HALTED <= 1'b1;
                    end else begin
                        PC <= next_pc;
                        if (RUN) begin
                            state       <= S_FETCH;
                            mem.MEM_REQ <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_HALT: begin
                    HALTED <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_issue_unit.sv
module tb_fetch_issue_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RUN = 1'b0;
    logic       JMP_SEL = 1'b0;
    logic [3:0] Opcode;
    logic [4:0] OPERAND;
    logic       INSTR_VALID;
    logic [4:0] PC;
    logic       HALTED;

    int tests_run = 0;
    int tests_failed = 0;

    fetch_issue_unit_if #(.PC_W(5), .INSTR_W(9)) mif ();

    fetch_issue_unit #(.PC_W(5), .INSTR_W(9), .HALT_OP(4'b1111)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RUN         (RUN),
        .mem         (mif),
        .Opcode      (Opcode),
        .OPERAND     (OPERAND),
        .INSTR_VALID (INSTR_VALID),
        .JMP_SEL     (JMP_SEL),
        .PC          (PC),
        .HALTED      (HALTED)
    );

    always #5 clk = ~clk;

    // Instruction memory model: fixed or random wait cycles per request,
    // plus a forced-ack mode for stray responses.
    logic [8:0] mem [32];
    int         fixed_wait = 0;
    bit         rand_wait = 1'b0;
    bit         force_ack = 1'b0;
    logic [8:0] force_data = '0;
    int         wait_left = 0;
    bit         busy = 1'b0;

    always @(negedge clk) begin
        if (force_ack) begin
            mif.MEM_ACK  = 1'b1;
            mif.MEM_DATA = force_data;
        end else if (mif.MEM_REQ === 1'b1) begin
            if (!busy) begin
                busy      = 1'b1;
                wait_left = rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
            end
            if (wait_left == 0) begin
                mif.MEM_ACK  = 1'b1;
                mif.MEM_DATA = mem[mif.MEM_ADDR];
                busy         = 1'b0;
            end else begin
                mif.MEM_ACK  = 1'b0;
                mif.MEM_DATA = 9'($urandom);
                wait_left--;
            end
        end else begin
            mif.MEM_ACK  = 1'b0;
            mif.MEM_DATA = 9'($urandom);
            busy         = 1'b0;
        end
    end

    typedef struct {
        int         req_cycles;
        int         first_req_idx;
        logic [4:0] first_addr;
        bit         addr_stable;
        int         ack_idx;
        int         valid_idx;
        logic [3:0] op;
        logic [4:0] opd;
        logic [4:0] pc;
        bit         timeout;
    } obs_t;

    // Reference model: opcode/operand fields and the next PC by plain arithmetic.
    function automatic int ref_op(input int w);
        return w / 32;
    endfunction

    function automatic int ref_opd(input int w);
        return w % 32;
    endfunction

    function automatic int ref_next_pc(input int pc, input int w, input bit jmp);
        if (w / 32 == 15) return pc;
        if (jmp) return w % 32;
        return (pc + 1) % 32;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        RUN       = 1'b0;
        JMP_SEL   = 1'b0;
        force_ack = 1'b0;
        rst_n     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Observes one fetch+issue, starting with the current cycle. Acts as the
    // control unit in ISSUE: jumps only on opcode 3 when jmp_on is set.
    task automatic issue_one(input bit jmp_on, input bit run_after, output obs_t o);
        o.req_cycles    = 0;
        o.first_req_idx = -1;
        o.first_addr    = '0;
        o.addr_stable   = 1'b0;
        o.ack_idx       = -1;
        o.valid_idx     = -1;
        o.op            = '0;
        o.opd           = '0;
        o.pc            = '0;
        o.timeout       = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (mif.MEM_REQ === 1'b1) begin
                if (o.first_req_idx < 0) begin
                    o.first_req_idx = i;
                    o.first_addr    = mif.MEM_ADDR;
                    o.addr_stable   = 1'b1;
                end else if (mif.MEM_ADDR !== o.first_addr) begin
                    o.addr_stable = 1'b0;
                end
                o.req_cycles++;
            end
            if (mif.MEM_ACK === 1'b1 && o.ack_idx < 0) o.ack_idx = i;
            if (INSTR_VALID === 1'b1) begin
                o.valid_idx = i;
                o.op        = Opcode;
                o.opd       = OPERAND;
                o.pc        = PC;
                o.timeout   = 1'b0;
                JMP_SEL     = jmp_on && (Opcode == 4'd3);
                RUN         = run_after;
                step();
                JMP_SEL = 1'b0;
                break;
            end
            step();
        end
    endtask

    task automatic run_to_pc(input int n, output bit ok);
        obs_t o;
        ok = 1'b1;
        do_reset();
        RUN = 1'b1;
        step();
        for (int i = 0; i < n; i++) begin
            issue_one(1'b0, 1'b1, o);
            if (o.timeout) ok = 1'b0;
        end
    endtask

    task automatic fill_linear();
        for (int i = 0; i < 32; i++) mem[i] = 9'((i % 3) * 32 + i);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (PC !== 5'd0 || mif.MEM_ADDR !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_pc: PC=%0d MEM_ADDR=%0d, required 0/0", PC, mif.MEM_ADDR);
        end
        tests_run++;
        if (Opcode !== 4'd0 || OPERAND !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_instr: Opcode=%0d OPERAND=%0d, required 0/0", Opcode, OPERAND);
        end
        tests_run++;
        if (mif.MEM_REQ !== 1'b0 || INSTR_VALID !== 1'b0 || HALTED !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: REQ=%b VALID=%b HALTED=%b, required 000",
                     mif.MEM_REQ, INSTR_VALID, HALTED);
        end
        begin
            bit any_req = 1'b0;
            for (int i = 0; i < 4; i++) begin
                step();
                if (mif.MEM_REQ !== 1'b0) any_req = 1'b1;
            end
            tests_run++;
            if (any_req) begin
                tests_failed++;
                $display("FAIL idle_no_req: MEM_REQ seen with RUN=0, required none");
            end
        end
    endtask

    task automatic test_sequence();
        obs_t o;
        fixed_wait = 0;
        rand_wait  = 1'b0;
        fill_linear();
        mem[0] = 9'h0A1;
        mem[1] = 9'h112;
        mem[2] = 9'h083;
        mem[3] = 9'h1C4;
        do_reset();
        RUN = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            issue_one(1'b0, 1'b1, o);
            tests_run++;
            if (o.timeout || o.first_req_idx != 0 || o.first_addr !== 5'(i)) begin
                tests_failed++;
                $display("FAIL seq_addr[%0d]: timeout=%b req_idx=%0d addr=%0d, required 0/0/%0d",
                         i, o.timeout, o.first_req_idx, o.first_addr, i);
            end
            tests_run++;
            if (o.op !== 4'(ref_op(int'(mem[i]))) || o.opd !== 5'(ref_opd(int'(mem[i])))) begin
                tests_failed++;
                $display("FAIL seq_instr[%0d]: got %0d/%0d, required %0d/%0d", i, o.op, o.opd,
                         ref_op(int'(mem[i])), ref_opd(int'(mem[i])));
            end
            tests_run++;
            if (o.valid_idx != 1 || o.req_cycles != 1) begin
                tests_failed++;
                $display("FAIL seq_period[%0d]: valid_idx=%0d req_cycles=%0d, required 1/1",
                         i, o.valid_idx, o.req_cycles);
            end
        end
    endtask

    task automatic test_wait_states();
        obs_t o;
        bit   ok;
        fill_linear();
        fixed_wait = 0;
        rand_wait  = 1'b0;
        run_to_pc(4, ok);
        // The wait count is picked at the start of a request, so this applies to PC=5.
        fixed_wait = 3;
        issue_one(1'b0, 1'b1, o);
        issue_one(1'b0, 1'b1, o);
        tests_run++;
        if (!ok || o.timeout || o.first_addr !== 5'd5 || o.req_cycles != 4 || !o.addr_stable) begin
            tests_failed++;
            $display("FAIL wait_hold: ok=%b timeout=%b addr=%0d req_cycles=%0d stable=%b, required 1/0/5/4/1",
                     ok, o.timeout, o.first_addr, o.req_cycles, o.addr_stable);
        end
        tests_run++;
        if (o.valid_idx - o.ack_idx != 1 || o.ack_idx - o.first_req_idx != 3) begin
            tests_failed++;
            $display("FAIL wait_ack_latency: ack_idx=%0d valid_idx=%0d, required valid=ack+1, ack=req+3",
                     o.ack_idx, o.valid_idx);
        end
        tests_run++;
        if (o.op !== 4'(ref_op(int'(mem[5]))) || o.opd !== 5'(ref_opd(int'(mem[5])))) begin
            tests_failed++;
            $display("FAIL wait_instr: got %0d/%0d, required %0d/%0d", o.op, o.opd,
                     ref_op(int'(mem[5])), ref_opd(int'(mem[5])));
        end
        fixed_wait = 0;
    endtask

    task automatic test_jump();
        obs_t o;
        bit   ok;
        int   exp_addr;
        fixed_wait = 0;
        rand_wait  = 1'b0;
        fill_linear();
        mem[7] = 9'h069;
        for (int j = 1; j >= 0; j--) begin
            run_to_pc(7, ok);
            issue_one(j[0], 1'b1, o);
            exp_addr = ref_next_pc(7, int'(mem[7]), j[0]);
            tests_run++;
            if (!ok || o.timeout || o.pc !== 5'd7 || o.op !== 4'd3) begin
                tests_failed++;
                $display("FAIL jump_setup[%0d]: ok=%b pc=%0d op=%0d, required pc 7 op 3", j, ok, o.pc, o.op);
            end
            issue_one(1'b0, 1'b1, o);
            tests_run++;
            if (o.timeout || o.first_addr !== 5'(exp_addr)) begin
                tests_failed++;
                $display("FAIL jump_target[%0d]: MEM_ADDR=%0d, required %0d", j, o.first_addr, exp_addr);
            end
        end
    endtask

    task automatic test_wrap();
        obs_t o;
        bit   ok;
        fill_linear();
        mem[31] = 9'h0A5;
        run_to_pc(31, ok);
        issue_one(1'b0, 1'b1, o);
        issue_one(1'b0, 1'b1, o);
        tests_run++;
        if (!ok || o.timeout || o.first_addr !== 5'(ref_next_pc(31, int'(mem[31]), 1'b0))) begin
            tests_failed++;
            $display("FAIL wrap: MEM_ADDR=%0d, required %0d", o.first_addr,
                     ref_next_pc(31, int'(mem[31]), 1'b0));
        end
    endtask

    task automatic test_halt();
        obs_t o;
        bit   ok;
        int   extra_valid = 0;
        bit   bad_state = 1'b0;
        fill_linear();
        mem[4] = 9'h1E0;
        run_to_pc(4, ok);
        issue_one(1'b0, 1'b1, o);
        tests_run++;
        if (!ok || o.timeout || o.op !== 4'(ref_op(int'(mem[4]))) || o.pc !== 5'd4) begin
            tests_failed++;
            $display("FAIL halt_issue: ok=%b op=%0d pc=%0d, required op 15 pc 4", ok, o.op, o.pc);
        end
        for (int i = 0; i < 12; i++) begin
            RUN = i[1];
            if (INSTR_VALID === 1'b1) extra_valid++;
            if (HALTED !== 1'b1 || mif.MEM_REQ !== 1'b0 || PC !== 5'(ref_next_pc(4, int'(mem[4]), 1'b0)))
                bad_state = 1'b1;
            step();
        end
        tests_run++;
        if (bad_state || extra_valid != 0) begin
            tests_failed++;
            $display("FAIL halt_hold: bad_state=%b extra_valid=%0d HALTED=%b REQ=%b PC=%0d, required 0/0/1/0/4",
                     bad_state, extra_valid, HALTED, mif.MEM_REQ, PC);
        end
        do_reset();
        tests_run++;
        if (HALTED !== 1'b0 || PC !== 5'd0) begin
            tests_failed++;
            $display("FAIL halt_reset_exit: HALTED=%b PC=%0d, required 0/0", HALTED, PC);
        end
    endtask

    task automatic test_pause();
        obs_t o;
        bit   ok;
        bit   bad_idle = 1'b0;
        fill_linear();
        run_to_pc(2, ok);
        issue_one(1'b0, 1'b0, o);
        for (int i = 0; i < 5; i++) begin
            if (mif.MEM_REQ !== 1'b0 || PC !== 5'd3 || INSTR_VALID !== 1'b0) bad_idle = 1'b1;
            step();
        end
        tests_run++;
        if (!ok || o.timeout || bad_idle) begin
            tests_failed++;
            $display("FAIL pause_idle: ok=%b timeout=%b bad=%b PC=%0d REQ=%b, required PC 3 REQ 0",
                     ok, o.timeout, bad_idle, PC, mif.MEM_REQ);
        end
        RUN = 1'b1;
        step();
        issue_one(1'b0, 1'b1, o);
        tests_run++;
        if (o.timeout || o.first_req_idx != 0 || o.first_addr !== 5'd3) begin
            tests_failed++;
            $display("FAIL pause_resume: req_idx=%0d addr=%0d, required 0/3", o.first_req_idx, o.first_addr);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        bit stray_valid = 1'b0;
        bit stray_req = 1'b0;
        fill_linear();
        fixed_wait = 3;
        run_to_pc(6, ok);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (!ok || mif.MEM_REQ !== 1'b0 || PC !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_fetch: ok=%b MEM_REQ=%b PC=%0d, required 1/0/0", ok, mif.MEM_REQ, PC);
        end
        RUN = 1'b0;
        step();
        rst_n      = 1'b1;
        force_data = 9'h1FF;
        force_ack  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (INSTR_VALID !== 1'b0) stray_valid = 1'b1;
            if (mif.MEM_REQ !== 1'b0) stray_req = 1'b1;
        end
        force_ack = 1'b0;
        tests_run++;
        if (stray_valid || stray_req || Opcode !== 4'd0 || OPERAND !== 5'd0) begin
            tests_failed++;
            $display("FAIL late_ack_ignored: valid=%b req=%b Opcode=%0d OPERAND=%0d, required 0/0/0/0",
                     stray_valid, stray_req, Opcode, OPERAND);
        end
        fixed_wait = 0;
    endtask

    task automatic test_random();
        obs_t o;
        int   exp_pc = 0;
        int   errs = 0;
        bit   jmp_on;
        bit   pause;
        for (int i = 0; i < 32; i++) mem[i] = 9'($urandom_range(0, 479));
        rand_wait = 1'b1;
        do_reset();
        RUN = 1'b1;
        step();
        for (int n = 0; n < 60; n++) begin
            jmp_on = 1'($urandom_range(0, 1));
            pause  = ($urandom_range(0, 5) == 0);
            issue_one(jmp_on, !pause, o);
            if (o.timeout || o.first_addr !== 5'(exp_pc) || !o.addr_stable ||
                o.req_cycles < 1 || o.req_cycles > 4 || o.valid_idx - o.ack_idx != 1 ||
                o.op !== 4'(ref_op(int'(mem[exp_pc]))) || o.opd !== 5'(ref_opd(int'(mem[exp_pc])))) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL random[%0d]: addr=%0d op=%0d opd=%0d req=%0d, required addr %0d op %0d opd %0d",
                             n, o.first_addr, o.op, o.opd, o.req_cycles, exp_pc,
                             ref_op(int'(mem[exp_pc])), ref_opd(int'(mem[exp_pc])));
            end
            exp_pc = ref_next_pc(exp_pc, int'(mem[exp_pc]), jmp_on && (ref_op(int'(mem[exp_pc])) == 3));
            if (pause) begin
                repeat ($urandom_range(0, 3)) begin
                    if (mif.MEM_REQ !== 1'b0) errs++;
                    step();
                end
                RUN = 1'b1;
                step();
            end
        end
        rand_wait = 1'b0;
        tests_run++;
        if (errs != 0) begin
            tests_failed++;
            $display("FAIL random_summary: %0d mismatching instructions, required 0", errs);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequence();
        test_wait_states();
        test_jump();
        test_wrap();
        test_halt();
        test_pause();
        test_reset_mid_fetch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
